// File: rtl/pwm_ctrl_pkg.sv
// Shared definitions for the PWM control stage: register map, bit positions, ramp FSM encoding
// and the saturating duty stepper.
package pwm_ctrl_pkg;

  localparam logic [2:0] IDX_CTRL     = 3'd0;
  localparam logic [2:0] IDX_PERIOD   = 3'd1;
  localparam logic [2:0] IDX_DUTY     = 3'd2;
  localparam logic [2:0] IDX_RAMP     = 3'd3;
  localparam logic [2:0] IDX_STATUS   = 3'd4;
  localparam logic [2:0] IDX_CUR_DUTY = 3'd5;

  localparam int CTRL_ENABLE_BIT     = 0;
  localparam int CTRL_RAMP_START_BIT = 1;
  localparam int CTRL_IRQ_EN_BIT     = 2;

  localparam int STATUS_BUSY_BIT = 0;
  localparam int STATUS_DONE_BIT = 1;

  typedef enum logic {
    RAMP_IDLE = 1'b0,
    RAMP_RUN  = 1'b1
  } ramp_state_t;

  // One step of cur toward target; 17-bit math so neither direction can wrap past the target.
  function automatic logic [15:0] ramp_step_value(input logic [15:0] cur,
                                                  input logic [15:0] target,
                                                  input logic [15:0] step);
    logic [16:0] sum;
    logic [16:0] diff;
    sum  = {1'b0, cur} + {1'b0, step};
    diff = {1'b0, cur} - {1'b0, step};
    if (cur < target) begin
      return (sum >= {1'b0, target}) ? target : sum[15:0];
    end else if (cur > target) begin
      return (diff[16] || (diff <= {1'b0, target})) ? target : diff[15:0];
    end else begin
      return target;
    end
  endfunction

endpackage

// File: rtl/pwm_ctrl_if.sv
// Peripheral bus port of the PWM control stage.
// Handshake: read or write is a one-cycle request strobe with no back-pressure; ack pulses exactly
// one cycle later and read_data is valid in that same cycle.
interface pwm_ctrl_if #(
  parameter int ADDR_WIDTH = 8
);
  logic                  read;
  logic                  write;
  logic [ADDR_WIDTH-1:0] address;
  logic [31:0]           write_data;
  logic [31:0]           read_data;
  logic                  ack;

  modport master (
    output read, write, address, write_data,
    input  read_data, ack
  );

  modport slave (
    input  read, write, address, write_data,
    output read_data, ack
  );
endinterface

// File: rtl/pwm_ctrl_ramp.sv
// Duty ramp engine: IDLE/RAMP FSM, period divider and saturating stepper toward the target duty.
module pwm_ctrl_ramp
  import pwm_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        start,
  input  logic        tick,
  input  logic [15:0] cur_duty,
  input  logic [15:0] target,
  input  logic [15:0] step,
  input  logic [15:0] div,
  input  logic        done_clr,
  output logic        duty_load,
  output logic [15:0] duty_new,
  output logic        done,
  output ramp_state_t state
);

  ramp_state_t state_q;
  ramp_state_t state_d;
  logic [15:0] div_cnt_q;
  logic [16:0] div_cnt_inc;
  logic [15:0] div_eff;
  logic        fire;
  logic        finish;
  logic        done_q;

  assign div_eff     = (div == 16'd0) ? 16'd1 : div;
  assign div_cnt_inc = {1'b0, div_cnt_q} + 17'd1;
  // A restart or an abort in the same cycle as the dividing tick suppresses the step.
  assign fire        = (state_q == RAMP_RUN) && enable && !start && tick &&
                       (div_cnt_inc >= {1'b0, div_eff});
  assign duty_new    = ramp_step_value(cur_duty, target, step);
  assign finish      = (duty_new == target) || (step == 16'd0);

  always_ff @(posedge clk) begin
    if (reset) state_q <= RAMP_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RAMP_IDLE: if (start && enable) state_d = RAMP_RUN;
      RAMP_RUN: begin
        if (!enable)            state_d = RAMP_IDLE;
        else if (start)         state_d = RAMP_RUN;
        else if (fire && finish) state_d = RAMP_IDLE;
      end
      default: state_d = RAMP_IDLE;
    endcase
  end

  always_comb begin
    duty_load = fire;
    state     = state_q;
    done      = done_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_q <= 16'd0;
      done_q    <= 1'b0;
    end else begin
      if (start && enable)                     div_cnt_q <= 16'd0;
      else if ((state_q == RAMP_RUN) && tick)  div_cnt_q <= fire ? 16'd0 : div_cnt_inc[15:0];
      if (fire && finish) done_q <= 1'b1;
      else if (done_clr)  done_q <= 1'b0;
    end
  end

endmodule

// File: rtl/pwm_ctrl.sv
// Bus-mapped PWM control stage: shadow registers committed on PWM period boundaries plus duty ramp.
// Optional interrupt on ramp completion when PWM_CTRL_IRQ_EN is defined.
module pwm_ctrl #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  pwm_ctrl_if.slave   bus,
  output logic [15:0] duty_cycle,
  output logic [15:0] period,
  output logic        irq
);
  import pwm_ctrl_pkg::*;

  logic [2:0]  idx;
  logic        enable_q, enable_d;
  logic [15:0] period_sh_q, period_sh_d;
  logic [15:0] duty_sh_q, duty_sh_d;
  logic [15:0] step_q, div_q;
  logic [15:0] period_active, duty_active;
  logic [15:0] cnt_q;
  logic        tick;
  logic        ramp_start, done_clr;
  logic        duty_load, busy, done;
  logic [15:0] duty_new;
  ramp_state_t ramp_state;
  logic [31:0] rdata_mux;
  logic [31:0] read_data_q;
  logic        ack_q;
  logic        irq_en_q;
  logic        unused_addr;

  assign idx         = bus.address[4:2];
  assign unused_addr = ^{bus.address[ADDR_WIDTH-1:5], bus.address[1:0]};

  // Next shadow values so a disabled commit already sees the write of this cycle.
  always_comb begin
    enable_d    = enable_q;
    period_sh_d = period_sh_q;
    duty_sh_d   = duty_sh_q;
    ramp_start  = 1'b0;
    done_clr    = 1'b0;
    if (bus.write) begin
      case (idx)
        IDX_CTRL: begin
          enable_d   = bus.write_data[CTRL_ENABLE_BIT];
          ramp_start = bus.write_data[CTRL_RAMP_START_BIT];
        end
        IDX_PERIOD: period_sh_d = bus.write_data[15:0];
        IDX_DUTY:   duty_sh_d   = bus.write_data[15:0];
        IDX_STATUS: done_clr    = bus.write_data[STATUS_DONE_BIT];
        default: ;
      endcase
    end
  end

  // Mirrors the PWM counter so commits land exactly on its wrap.
  assign tick = enable_q && (cnt_q >= period_active);

  always_ff @(posedge clk) begin
    if (reset) begin
      enable_q      <= 1'b0;
      period_sh_q   <= 16'd0;
      duty_sh_q     <= 16'd0;
      step_q        <= 16'd0;
      div_q         <= 16'd0;
      cnt_q         <= 16'd0;
      period_active <= 16'd0;
      duty_active   <= 16'd0;
    end else begin
      enable_q    <= enable_d;
      period_sh_q <= period_sh_d;
      duty_sh_q   <= duty_sh_d;
      if (bus.write && (idx == IDX_RAMP)) begin
        step_q <= bus.write_data[15:0];
        div_q  <= bus.write_data[31:16];
      end
      if (!enable_q || tick) cnt_q <= 16'd0;
      else                   cnt_q <= cnt_q + 16'd1;
      if (!enable_q || tick) period_active <= period_sh_d;
      if (!enable_q)              duty_active <= duty_sh_d;
      else if (duty_load)         duty_active <= duty_new;
      else if (tick && !busy)     duty_active <= duty_sh_d;
    end
  end

`ifdef PWM_CTRL_IRQ_EN
  always_ff @(posedge clk) begin
    if (reset) irq_en_q <= 1'b0;
    else if (bus.write && (idx == IDX_CTRL)) irq_en_q <= bus.write_data[CTRL_IRQ_EN_BIT];
  end
  assign irq = done & irq_en_q;
`else
  assign irq_en_q = 1'b0;
  assign irq      = 1'b0;
`endif

  pwm_ctrl_ramp u_ramp (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable_d),
    .start     (ramp_start),
    .tick      (tick),
    .cur_duty  (duty_active),
    .target    (duty_sh_q),
    .step      (step_q),
    .div       (div_q),
    .done_clr  (done_clr),
    .duty_load (duty_load),
    .duty_new  (duty_new),
    .done      (done),
    .state     (ramp_state)
  );

  assign busy = (ramp_state == RAMP_RUN);

  always_comb begin
    rdata_mux = 32'd0;
    case (idx)
      IDX_CTRL: begin
        rdata_mux[CTRL_ENABLE_BIT] = enable_q;
        rdata_mux[CTRL_IRQ_EN_BIT] = irq_en_q;
      end
      IDX_PERIOD:   rdata_mux[15:0] = period_sh_q;
      IDX_DUTY:     rdata_mux[15:0] = duty_sh_q;
      IDX_RAMP:     rdata_mux       = {div_q, step_q};
      IDX_STATUS: begin
        rdata_mux[STATUS_BUSY_BIT] = busy;
        rdata_mux[STATUS_DONE_BIT] = done;
      end
      IDX_CUR_DUTY: rdata_mux[15:0] = duty_cycle;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ack_q       <= 1'b0;
      read_data_q <= 32'd0;
    end else begin
      ack_q       <= bus.read | bus.write;
      read_data_q <= (bus.read && !bus.write) ? rdata_mux : 32'd0;
    end
  end

  assign bus.ack       = ack_q;
  assign bus.read_data = read_data_q;
  assign duty_cycle    = enable_q ? duty_active : 16'd0;
  assign period        = period_active;

endmodule

// File: tb/tb_pwm_ctrl.sv
// Directed bench for pwm_ctrl: register-map vector table plus commit, ramp, abort, irq and reset sequences.
module tb_pwm_ctrl;
  import pwm_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] duty_cycle;
  logic [15:0] period;
  logic        irq;
  int          checks = 0;
  int          errors = 0;

  logic [15:0] exp_q[$];
  int          exp_cyc_q[$];

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  idx;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic [15:0] exp_period;
    logic [15:0] exp_duty;
  } vec_t;

  vec_t vecs[20];

  pwm_ctrl_if #(.ADDR_WIDTH(8)) bus ();

  pwm_ctrl #(.ADDR_WIDTH(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .duty_cycle (duty_cycle),
    .period     (period),
    .irq        (irq)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // driver tasks: called at a negedge, return at the negedge after the strobe's active edge
  task automatic bus_cycle(input logic rd, input logic wr, input logic [2:0] idx,
                           input logic [31:0] wd, output logic [31:0] rdata);
    bus.read       = rd;
    bus.write      = wr;
    bus.address    = {3'b101, idx, 2'b11};
    bus.write_data = wd;
    @(negedge clk);
    check("ack", 32'(bus.ack), 32'd1);
    rdata      = bus.read_data;
    bus.read   = 1'b0;
    bus.write  = 1'b0;
  endtask

  task automatic bus_write(input logic [2:0] idx, input logic [31:0] wd);
    logic [31:0] d;
    bus_cycle(1'b0, 1'b1, idx, wd, d);
  endtask

  task automatic bus_read_check(input string name, input logic [2:0] idx, input logic [31:0] exp);
    logic [31:0] d;
    bus_cycle(1'b1, 1'b0, idx, 32'd0, d);
    check(name, d, exp);
  endtask

  // scoreboard: each duty change must match the head of exp_q at the cycle in exp_cyc_q
  task automatic run_ramp_monitor(input int cyc0, input logic [15:0] last0, input int budget);
    int          cyc  = cyc0;
    logic [15:0] last = last0;
    while (exp_q.size() > 0 && cyc < cyc0 + budget) begin
      @(negedge clk);
      cyc++;
      if (duty_cycle !== last) begin
        check("ramp_duty", 32'(duty_cycle), 32'(exp_q.pop_front()));
        check("ramp_cycle", 32'(cyc), 32'(exp_cyc_q.pop_front()));
        last = duty_cycle;
      end
    end
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL ramp_timeout: %0d steps outstanding, expected 0", exp_q.size());
      exp_q.delete();
      exp_cyc_q.delete();
    end
  endtask

  initial begin
    logic [31:0] d;
    int          n;

    reset          = 1'b1;
    bus.read       = 1'b0;
    bus.write      = 1'b0;
    bus.address    = '0;
    bus.write_data = '0;
    repeat (3) @(negedge clk);
    check("rst_ack", 32'(bus.ack), 32'd0);
    check("rst_rdata", bus.read_data, 32'd0);
    check("rst_period", 32'(period), 32'd0);
    check("rst_duty", 32'(duty_cycle), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    reset = 1'b0;

    // register map while disabled: period follows shadow next cycle, duty forced 0
    vecs[0]  = '{0, 1, IDX_PERIOD,   32'd9,          32'd0,          16'd9, 16'd0};
    vecs[1]  = '{0, 1, IDX_DUTY,     32'd4,          32'd0,          16'd9, 16'd0};
    vecs[2]  = '{1, 0, IDX_PERIOD,   32'd0,          32'd9,          16'd9, 16'd0};
    vecs[3]  = '{1, 0, IDX_DUTY,     32'd0,          32'd4,          16'd9, 16'd0};
    vecs[4]  = '{0, 1, IDX_RAMP,     32'h0002_0003,  32'd0,          16'd9, 16'd0};
    vecs[5]  = '{1, 0, IDX_RAMP,     32'd0,          32'h0002_0003,  16'd9, 16'd0};
    vecs[6]  = '{1, 0, 3'd6,         32'd0,          32'd0,          16'd9, 16'd0};
    vecs[7]  = '{0, 1, 3'd7,         32'hFFFF_FFFF,  32'd0,          16'd9, 16'd0};
    vecs[8]  = '{1, 0, 3'd7,         32'd0,          32'd0,          16'd9, 16'd0};
    vecs[9]  = '{1, 0, IDX_CTRL,     32'd0,          32'd0,          16'd9, 16'd0};
    vecs[10] = '{1, 0, IDX_STATUS,   32'd0,          32'd0,          16'd9, 16'd0};
    vecs[11] = '{1, 0, IDX_CUR_DUTY, 32'd0,          32'd0,          16'd9, 16'd0};
    vecs[12] = '{0, 1, IDX_PERIOD,   32'hABCD_0009,  32'd0,          16'd9, 16'd0};
    vecs[13] = '{1, 0, IDX_PERIOD,   32'd0,          32'd9,          16'd9, 16'd0};
    vecs[14] = '{1, 1, IDX_DUTY,     32'd6,          32'd0,          16'd9, 16'd0};
    vecs[15] = '{1, 0, IDX_DUTY,     32'd0,          32'd6,          16'd9, 16'd0};
    vecs[16] = '{0, 1, IDX_DUTY,     32'd4,          32'd0,          16'd9, 16'd0};
    vecs[17] = '{0, 1, IDX_CTRL,     32'd2,          32'd0,          16'd9, 16'd0};
    vecs[18] = '{1, 0, IDX_STATUS,   32'd0,          32'd0,          16'd9, 16'd0};
    vecs[19] = '{1, 0, IDX_CTRL,     32'd0,          32'd0,          16'd9, 16'd0};

    @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      bus_cycle(vecs[i].rd, vecs[i].wr, vecs[i].idx, vecs[i].wdata, d);
      if (vecs[i].rd) check($sformatf("vec%0d_rdata", i), d, vecs[i].exp_rdata);
      check($sformatf("vec%0d_period", i), 32'(period), 32'(vecs[i].exp_period));
      check($sformatf("vec%0d_duty", i), 32'(duty_cycle), 32'(vecs[i].exp_duty));
    end

    // enable, then mid-period duty write holds until the counter wraps 9 -> 0
    bus_write(IDX_CTRL, 32'd1);
    bus_write(IDX_DUTY, 32'd7);
    for (int i = 1; i < 10; i++) begin
      check($sformatf("commit_hold_c%0d", i), 32'(duty_cycle), 32'd4);
      @(negedge clk);
    end
    check("commit_tick", 32'(duty_cycle), 32'd7);
    check("commit_period", 32'(period), 32'd9);

    // ramp up 0 -> 10, step 3, div 2
    bus_write(IDX_CTRL, 32'd0);
    bus_write(IDX_DUTY, 32'd0);
    bus_write(IDX_CTRL, 32'd1);
    bus_write(IDX_DUTY, 32'd10);
    bus_write(IDX_CTRL, 32'd3);
    bus_read_check("ramp_up_busy", IDX_STATUS, 32'd1);
    exp_q     = '{16'd3, 16'd6, 16'd9, 16'd10};
    exp_cyc_q = '{20, 40, 60, 80};
    run_ramp_monitor(3, 16'd0, 120);
    bus_read_check("ramp_up_done", IDX_STATUS, 32'd2);
    bus_read_check("ramp_up_cur", IDX_CUR_DUTY, 32'd10);
    bus_write(IDX_STATUS, 32'd2);
    bus_read_check("done_w1c", IDX_STATUS, 32'd0);

    // ramp down with saturation: 0xFFFF -> 0x7FFF -> 0x0001
    bus_write(IDX_CTRL, 32'd0);
    bus_write(IDX_DUTY, 32'hFFFF);
    bus_write(IDX_RAMP, 32'h0001_8000);
    bus_write(IDX_CTRL, 32'd1);
    bus_write(IDX_DUTY, 32'd1);
    bus_write(IDX_CTRL, 32'd3);
    exp_q     = '{16'h7FFF, 16'h0001};
    exp_cyc_q = '{10, 20};
    run_ramp_monitor(2, 16'hFFFF, 60);
    bus_read_check("ramp_down_done", IDX_STATUS, 32'd2);

    // enable cleared mid-ramp aborts without setting done
    bus_write(IDX_CTRL, 32'd0);
    bus_write(IDX_STATUS, 32'd2);
    bus_write(IDX_RAMP, 32'h0002_0001);
    bus_write(IDX_CTRL, 32'd1);
    bus_write(IDX_DUTY, 32'h0100);
    bus_write(IDX_CTRL, 32'd3);
    bus_read_check("abort_busy", IDX_STATUS, 32'd1);
    bus_write(IDX_CTRL, 32'd0);
    check("abort_duty", 32'(duty_cycle), 32'd0);
    bus_read_check("abort_status", IDX_STATUS, 32'd0);
    bus_read_check("abort_cur", IDX_CUR_DUTY, 32'd0);

`ifdef PWM_CTRL_IRQ_EN
    bus_write(IDX_CTRL, 32'd5);
    bus_write(IDX_DUTY, 32'h0102);
    bus_write(IDX_CTRL, 32'd7);
    bus_read_check("irq_ctrl", IDX_CTRL, 32'd5);
    check("irq_low", 32'(irq), 32'd0);
    n = 0;
    while (irq !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("irq_set", 32'(irq), 32'd1);
    bus_write(IDX_STATUS, 32'd2);
    check("irq_clr", 32'(irq), 32'd0);
`else
    bus_write(IDX_CTRL, 32'd5);
    bus_read_check("ctrl_no_irq_en", IDX_CTRL, 32'd1);
    check("irq_tied", 32'(irq), 32'd0);
    n = 0;
`endif

    // reset in the middle of a ramp
    bus_write(IDX_CTRL, 32'd3);
    bus_read_check("rst_ramp_busy", IDX_STATUS, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst2_period", 32'(period), 32'd0);
    check("rst2_duty", 32'(duty_cycle), 32'd0);
    check("rst2_ack", 32'(bus.ack), 32'd0);
    check("rst2_irq", 32'(irq), 32'd0);
    bus_read_check("rst2_status", IDX_STATUS, 32'd0);
    bus_read_check("rst2_period_reg", IDX_PERIOD, 32'd0);

    // report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
